mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Sequencer for the shared 32x32 signed Booth multiplier (64-bit combinational product). Gives the RV32M execute stage a valid/ready port for MUL, MULH, MULHSU and MULHU.
- Registers the operands and drives them to the multiplier instance at top level. Captures the 64-bit product, then applies the unsigned sign corrections, because the datapath is signed-only.
- Selects the 32-bit result and holds it until the consumer accepts it.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.
- FAST_ZERO, 1, when 1 a zero operand skips the CALC/FIX states and responds early.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req_op1  in  32  rs1 value.
- req_op2  in  32  rs2 value.
- req_tag  in  TAG_W  request tag.
- flush  in  1  kill the in-flight operation (pipeline flush).
- mul_a  out  32  operand A driven to the shared signed multiplier.
- mul_b  out  32  operand B driven to the shared signed multiplier.
- mul_p  in  64  signed product from the multiplier, combinational on mul_a/mul_b.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_res  out  32  result.
- rsp_tag  out  TAG_W  tag of the response.
- busy  out  1  asserted when state != IDLE.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (async, rst_n=0):
  - state=IDLE.
  - mul_a, mul_b, rsp_res, rsp_tag, product register and operand registers are all 0.
  - rsp_valid=0, busy=0, req_ready=0 while rst_n is low.
- req_ready = (state==IDLE) & rst_n. There is no accept in any other state, including DONE on the same cycle as the rsp handshake.
- IDLE: on req_valid&req_ready, latch op1, op2, op and tag; mul_a/mul_b take op1/op2 from the registers.
  - If FAST_ZERO=1 and (op1==0 | op2==0): go to DONE with rsp_res=0.
  - Otherwise go to CALC.
- CALC: one cycle for multiplier settling. At the clock edge, P <= mul_p; go to FIX.
- FIX: compute the correction mod 2^64, register rsp_res and set rsp_valid=1; go to DONE.
  - MUL: res = P[31:0].
  - MULH: res = P[63:32].
  - MULHSU: Q = P + (op2[31] ? {op1,32'b0} : 0); res = Q[63:32].
  - MULHU: Q = P + (op1[31] ? {op2,32'b0} : 0) + (op2[31] ? {op1,32'b0} : 0); res = Q[63:32].
- DONE: rsp_valid=1. rsp_res and rsp_tag stay stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE and clear rsp_valid.
- Latency, accept edge to rsp_valid high:
  - 3 cycles on the normal path (accept at cycle 0 edge, CALC, FIX, rsp_valid visible after the FIX edge).
  - 1 cycle on the FAST_ZERO path.
- Throughput: at most one operation per 4 cycles with rsp_ready held high.
- flush:
  - In CALC, FIX or DONE: next state IDLE, rsp_valid=0, no response is ever produced for the killed op.
  - Flush in IDLE ignores any request that cycle (req_ready is still 1, but no capture).
  - flush overrides a simultaneous rsp handshake; the response is dropped.
- mul_a/mul_b hold their last values in IDLE; there is no toggling on an idle bus.
- Undefined req_op is not possible, since all 4 codes are used.

Decomposition:
- Shared package mul_pkg:
  - op encodings MUL_OP_MUL/MULH/MULHSU/MULHU (values 2'b00..2'b11, matching funct3[1:0]).
  - state encodings ST_IDLE/ST_CALC/ST_FIX/ST_DONE.
- One natural sub-module: mul_fixup. It is combinational, takes P, op1, op2 and op, and returns the 32-bit result. It is unit-testable in isolation against a reference model.

Test Plan:
- MUL: op1=7, op2=0xFFFFFFFD -> rsp_res=0xFFFFFFEB, rsp_valid exactly 3 cycles after accept, rsp_tag echoed.
- MULH vs MULHU: op1=op2=0xFFFFFFFF.
  - MULH -> 0x00000000.
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
- Sign corner: op1=op2=0x80000000.
  - MULH -> 0x40000000.
  - MULHU -> 0x40000000.
  - MULHSU -> 0xC0000000.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_res/rsp_tag stable, req_ready=0. Raise rsp_ready -> IDLE next cycle, next request accepted.
- Flush: assert flush in CALC, and separately in DONE -> rsp_valid never seen for that tag, req_ready=1 on the following cycle. Deassert rst_n mid-FIX -> all outputs 0 immediately, without waiting for a clock edge.
- FAST_ZERO=1: op1=0, op2=0x12345678, MULHU -> rsp_res=0 one cycle after accept. With FAST_ZERO=0 the same stimulus takes 3 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the RV32M multiply sequencer.
//   mul_op_t : operation codes, equal to funct3[1:0] of MUL/MULH/MULHSU/MULHU.
//   state_t  : controller state encoding (IDLE, CALC, FIX, DONE).
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_fixup.sv
// mul_fixup: turns the signed 32x32 product into the RV32M result.
// Ports:
//   p   in  64  signed product of op1*op2
//   op1 in  32  rs1 value
//   op2 in  32  rs2 value
//   op  in  2   operation (mul_op_t)
//   res out 32  selected / corrected result
// An operand read as unsigned equals its signed value plus 2^32 when bit 31
// is set, so the unsigned product differs from the signed one by
// (other operand << 32) for each such operand. All arithmetic is mod 2^64.
module mul_fixup
  import mul_pkg::*;
(
  input  logic [63:0] p,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  mul_op_t     op,
  output logic [31:0] res
);

  logic [63:0] corr1;
  logic [63:0] corr2;
  logic [63:0] q;

  always_comb begin
    corr1 = op1[31] ? {op2, 32'b0} : 64'b0;
    corr2 = op2[31] ? {op1, 32'b0} : 64'b0;
    q     = p;
    case (op)
      MUL_OP_MULHSU: q = p + corr2;
      MUL_OP_MULHU:  q = p + corr1 + corr2;
      default:       q = p;
    endcase
    res = (op == MUL_OP_MUL) ? q[31:0] : q[63:32];
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: valid/ready sequencer around the shared signed multiplier.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake
//   req_op/req_op1/req_op2     operation and operands
//   req_tag                    opaque tag echoed on the response
//   flush                      kill the in-flight operation
//   mul_a/mul_b/mul_p          shared multiplier operands and product
//   rsp_valid/rsp_ready        response handshake
//   rsp_res/rsp_tag            result and tag
//   busy                       state != IDLE
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
// flush in the same cycle cancels either transfer.
// Flow: IDLE -accept-> CALC (multiplier settles) -> FIX (result corrected
// and registered) -> DONE (held until rsp_ready). A zero operand may jump
// straight from IDLE to DONE with result 0 when FAST_ZERO is set.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_op1,
  input  logic [31:0]      req_op2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_p,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_res,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  mul_op_t     op_q;
  logic [63:0] p_q;
  logic [31:0] fix_res;
  logic        accept;
  logic        zero_hit;
  logic        fast;

  // Operand registers drive the multiplier directly, so the bus only moves
  // when a new request is captured.
  assign mul_a    = op1_q;
  assign mul_b    = op2_q;
  assign zero_hit = (req_op1 == 32'd0) || (req_op2 == 32'd0);
  assign fast     = FAST_ZERO && zero_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = fast ? ST_DONE : ST_CALC;
      ST_CALC: state_nxt = flush ? ST_IDLE : ST_FIX;
      ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
      ST_DONE: if (flush || rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and datapath strobes
  always_comb begin
    req_ready = (state == ST_IDLE) && rst_n;
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_DONE);
    // A flush in IDLE suppresses capture even though req_ready stays high.
    accept    = req_valid && req_ready && !flush;
  end

  mul_fixup u_fixup (
    .p   (p_q),
    .op1 (op1_q),
    .op2 (op2_q),
    .op  (op_q),
    .res (fix_res)
  );

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q   <= '0;
      op2_q   <= '0;
      op_q    <= MUL_OP_MUL;
      p_q     <= '0;
      rsp_res <= '0;
      rsp_tag <= '0;
    end else begin
      if (accept) begin
        op1_q   <= req_op1;
        op2_q   <= req_op2;
        op_q    <= mul_op_t'(req_op);
        rsp_tag <= req_tag;
        if (fast) rsp_res <= '0;
      end
      if ((state == ST_CALC) && !flush) p_q <= mul_p;
      if ((state == ST_FIX) && !flush) rsp_res <= fix_res;
    end
  end

endmodule
